// File: rtl/ysyx_24080014_lsu_pkg.sv
// Shared types and helpers for the ysyx_24080014 load/store unit:
// FSM state encoding, RV32 funct3 codes and the request-legality/alignment check.
package ysyx_24080014_lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Word-aligned memory address for a byte address.
   function automatic logic [31:0] lsu_word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // True when funct3 is legal for the access direction and the address is
   // naturally aligned for the access size.
   function automatic logic lsu_req_ok(input logic       wen,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_LB:   ok = 1'b1;
         F3_LH:   ok = (addr_lo[0] == 1'b0);
         F3_LW:   ok = (addr_lo == 2'b00);
         F3_LBU:  ok = !wen;
         F3_LHU:  ok = !wen && (addr_lo[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Combinational lane logic for the LSU: store byte-mask / data replication
// and load byte/half extraction with sign or zero extension.
module ysyx_24080014_lsu_align
   import ysyx_24080014_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_addr_lo_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  st_wmask_o,
   output logic [31:0] st_wdata_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift_s;

   // Store side: byte enables and lane-replicated write data.
   always_comb begin
      st_wmask_o = 4'b0000;
      st_wdata_o = 32'h0000_0000;
      case (st_funct3_i)
         F3_SB: begin
            st_wmask_o = 4'b0001 << st_addr_lo_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
         end
         F3_SH: begin
            st_wmask_o = 4'b0011 << {st_addr_lo_i[1], 1'b0};
            st_wdata_o = {2{st_wdata_i[15:0]}};
         end
         F3_SW: begin
            st_wmask_o = 4'b1111;
            st_wdata_o = st_wdata_i;
         end
         default: begin
            st_wmask_o = 4'b0000;
            st_wdata_o = 32'h0000_0000;
         end
      endcase
   end

   // Load side: shift addressed lane to bit 0 then extend; LW is only legal
   // with addr_lo == 0, so the shifted word equals the raw word there.
   always_comb begin
      ld_shift_s = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
      case (ld_funct3_i)
         F3_LB:   ld_data_o = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
         F3_LH:   ld_data_o = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
         F3_LW:   ld_data_o = ld_shift_s;
         F3_LBU:  ld_data_o = {24'h00_0000, ld_shift_s[7:0]};
         F3_LHU:  ld_data_o = {16'h0000, ld_shift_s[15:0]};
         default: ld_data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014 load/store unit: one outstanding load/store between EXU and
// the single-port data memory, result returned to WBU. All outputs registered.
// Optional read-wait timeout enabled by defining YSYX_24080014_LSU_TIMEOUT_EN.
module ysyx_24080014_lsu
   import ysyx_24080014_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   lsu_state_e  state_q;
   logic        wen_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic        mem_ren_q;
   logic        mem_wen_q;
   logic [31:0] mem_raddr_q;
   logic [31:0] mem_waddr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wmask_q;

   logic [3:0]  st_wmask_s;
   logic [31:0] st_wdata_s;
   logic [31:0] ld_data_s;
   logic        req_ok_s;

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q;
`endif

   // Store lanes come from the incoming request; load extraction uses the
   // latched access descriptor against the live memory data.
   ysyx_24080014_lsu_align u_align (
      .st_funct3_i  (req_funct3),
      .st_addr_lo_i (req_addr[1:0]),
      .st_wdata_i   (req_wdata),
      .st_wmask_o   (st_wmask_s),
      .st_wdata_o   (st_wdata_s),
      .ld_funct3_i  (funct3_q),
      .ld_addr_lo_i (addr_lo_q),
      .ld_rdata_i   (mem_rdata),
      .ld_data_o    (ld_data_s)
   );

   assign req_ok_s = lsu_req_ok(req_wen, req_funct3, req_addr[1:0]);

   // Request FSM with all interface outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wen_q        <= 1'b0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
         mem_ren_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_raddr_q  <= 32'h0000_0000;
         mem_waddr_q  <= 32'h0000_0000;
         mem_wdata_q  <= 32'h0000_0000;
         mem_wmask_q  <= 4'b0000;
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
         wait_cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  wen_q       <= req_wen;
                  funct3_q    <= req_funct3;
                  addr_lo_q   <= req_addr[1:0];
                  req_ready_q <= 1'b0;
                  if (req_ok_s) begin
                     state_q     <= S_ISSUE;
                     mem_ren_q   <= !req_wen;
                     mem_wen_q   <= req_wen;
                     mem_raddr_q <= lsu_word_addr(req_addr);
                     mem_waddr_q <= lsu_word_addr(req_addr);
                     mem_wmask_q <= req_wen ? st_wmask_s : 4'b0000;
                     mem_wdata_q <= req_wen ? st_wdata_s : 32'h0000_0000;
                  end else begin
                     // Illegal or misaligned: answer immediately, no strobe.
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0000_0000;
                  end
               end
            end
            S_ISSUE: begin
               mem_ren_q <= 1'b0;
               mem_wen_q <= 1'b0;
               if (wen_q) begin
                  // Stores are posted: no write acknowledge from memory.
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= 32'h0000_0000;
               end else begin
                  state_q <= S_WAIT;
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
                  wait_cnt_q <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (mem_ready) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= ld_data_s;
               end
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
               else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0000_0000;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
`endif
            end
            S_RESP: begin
               if (resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= 32'h0000_0000;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               mem_ren_q    <= 1'b0;
               mem_wen_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_ren    = mem_ren_q;
   assign mem_wen    = mem_wen_q;
   assign mem_raddr  = mem_raddr_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = {4'b0000, mem_wmask_q};

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for ysyx_24080014_lsu: loads, stores, error requests,
// response back-pressure and mid-operation reset, cycle by cycle.
// Define YSYX_24080014_LSU_TIMEOUT_EN to also exercise the read timeout.
module tb_ysyx_24080014_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ysyx_24080014_lsu #(.TIMEOUT_CYCLES(4)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_raddr  (mem_raddr),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle (accepted at the next posedge) and
   // return after the accepting edge, at the following negedge.
   task automatic send(input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_wen    = wen;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(negedge clk);
      req_valid  = 1'b0;
      req_wdata  = 32'h5555_5555;
   endtask

   task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
      send(1'b0, f3, addr, 32'h0);
      // ISSUE: one read strobe; a stray mem_ready here must be ignored
      chk({tag, "_ren"}, {31'd0, mem_ren}, 32'd1);
      chk({tag, "_wen0"}, {31'd0, mem_wen}, 32'd0);
      chk({tag, "_raddr"}, mem_raddr, exp_addr);
      chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      // WAIT
      chk({tag, "_ren_drop"}, {31'd0, mem_ren}, 32'd0);
      chk({tag, "_nv_wait"}, {31'd0, resp_valid}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hA5A5_A5A5;
      chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp_data);
      chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [7:0] exp_mask,
                           input logic [31:0] exp_wd, input logic [31:0] exp_addr);
      send(1'b1, f3, addr, wd);
      chk({tag, "_wen"}, {31'd0, mem_wen}, 32'd1);
      chk({tag, "_ren0"}, {31'd0, mem_ren}, 32'd0);
      chk({tag, "_wmask"}, {24'd0, mem_wmask}, {24'd0, exp_mask});
      chk({tag, "_wdata"}, mem_wdata, exp_wd);
      chk({tag, "_waddr"}, mem_waddr, exp_addr);
      @(negedge clk);
      chk({tag, "_wen_drop"}, {31'd0, mem_wen}, 32'd0);
      chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic err_op(input string tag, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr);
      send(wen, f3, addr, 32'hFFFF_FFFF);
      chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_err"}, {31'd0, resp_err}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_nostrobe"}, {30'd0, mem_ren, mem_wen}, 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_nostrobe2"}, {30'd0, mem_ren, mem_wen}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b1;
      mem_rdata  = 32'h0;
      mem_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp", {29'd0, resp_valid, resp_err, mem_ren}, 32'd0);
      chk("rst_wen", {31'd0, mem_wen}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_addr", mem_raddr | mem_waddr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_wmask", {24'd0, mem_wmask}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      load_op("lw",  3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
      load_op("lb",  3'b000, 32'h8000_0003, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80);
      load_op("lbu", 3'b100, 32'h8000_0003, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0080);
      load_op("lh",  3'b001, 32'h8000_0002, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_80FF);
      load_op("lhu", 3'b101, 32'h8000_0002, 32'h80FF_1234, 32'h8000_0000, 32'h0000_80FF);
      load_op("lb1", 3'b000, 32'h8000_0001, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0012);

      store_op("sb", 3'b000, 32'h8000_0002, 32'h0000_00AB, 8'h04, 32'hABAB_ABAB, 32'h8000_0000);
      store_op("sh", 3'b001, 32'h8000_0002, 32'h1234_CDEF, 8'h0C, 32'hCDEF_CDEF, 32'h8000_0000);
      store_op("sw", 3'b010, 32'h8000_0008, 32'h1234_5678, 8'h0F, 32'h1234_5678, 32'h8000_0008);

      err_op("sh_mis", 1'b1, 3'b001, 32'h8000_0003);
      err_op("ld_f3",  1'b0, 3'b011, 32'h8000_0000);
      err_op("lw_mis", 1'b0, 3'b010, 32'h8000_0002);
      err_op("st_f3",  1'b1, 3'b100, 32'h8000_0000);

      // Back-pressure: result held 5 cycles, new requests refused meanwhile.
      resp_ready = 1'b0;
      send(1'b0, 3'b010, 32'h8000_0010, 32'h0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_funct3 = 3'b010;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_rdata", resp_rdata, 32'hCAFE_F00D);
         chk("bp_ready", {31'd0, req_ready}, 32'd0);
         chk("bp_nostrobe", {30'd0, mem_ren, mem_wen}, 32'd0);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {31'd0, resp_valid}, 32'd0);
      chk("bp_idle", {31'd0, req_ready}, 32'd1);

      // Reset during WAIT aborts the load; a late mem_ready is ignored.
      send(1'b0, 3'b010, 32'h8000_0020, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_wait_strobe", {30'd0, mem_ren, mem_wen}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_1111;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_after_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_after_strobe", {30'd0, mem_ren, mem_wen}, 32'd0);
      chk("rst_after_ready", {31'd0, req_ready}, 32'd1);

`ifdef YSYX_24080014_LSU_TIMEOUT_EN
      // Timeout after 4 WAIT cycles without mem_ready.
      send(1'b0, 3'b010, 32'h8000_0030, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_pending", {31'd0, resp_valid}, 32'd0);
      end
      @(negedge clk);
      chk("to_valid", {31'd0, resp_valid}, 32'd1);
      chk("to_err", {31'd0, resp_err}, 32'd1);
      chk("to_rdata", resp_rdata, 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("to_done", {31'd0, resp_valid}, 32'd0);
      chk("to_idle", {31'd0, req_ready}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
